// File: rtl/decoder_nto2n_seq.sv
// Registered IN_W-to-2**IN_W one-hot decoder with latch, timed-pulse and
// wrapping-sweep modes behind a valid/ready command interface.
module decoder_nto2n_seq #(
   parameter  int IN_W      = 3,
   parameter  int PULSE_LEN = 1,
   localparam int OUT_W     = 2 ** IN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             abort,
   output logic [OUT_W-1:0] out,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(PULSE_LEN + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PULSE,
      S_SWEEP
   } state_t;

   typedef enum logic [1:0] {
      MODE_LATCH = 2'b00,
      MODE_PULSE = 2'b01,
      MODE_SWEEP = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_t;

   state_t             state_q, state_d;
   logic [OUT_W-1:0]   out_d;
   logic               done_d;
   logic [CNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
   logic [IN_W-1:0]    sweep_idx_q, sweep_idx_d;
   logic [OUT_W-1:0]   one_hot;

   assign one_hot  = OUT_W'(1) << in;
   assign in_ready = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      out_d       = out;
      done_d      = 1'b0;
      pulse_cnt_d = pulse_cnt_q;
      sweep_idx_d = sweep_idx_q;

      if (abort) begin
         state_d     = S_IDLE;
         out_d       = '0;
         pulse_cnt_d = '0;
         sweep_idx_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  out_d       = '0;
                  pulse_cnt_d = '0;
                  sweep_idx_d = '0;
                  if (enable) begin
                     unique case (mode_t'(mode))
                        MODE_LATCH: out_d = one_hot;
                        MODE_PULSE: begin
                           out_d       = one_hot;
                           pulse_cnt_d = CNT_W'(1);
                           state_d     = S_PULSE;
                        end
                        MODE_SWEEP: begin
                           out_d   = one_hot;
                           state_d = S_SWEEP;
                        end
                        MODE_RSVD:  out_d = '0;
                     endcase
                  end
               end
            end
            S_PULSE: begin
               // The counter holds how many output cycles have already been shown.
               if (pulse_cnt_q == CNT_W'(PULSE_LEN)) begin
                  state_d     = S_IDLE;
                  out_d       = '0;
                  done_d      = 1'b1;
                  pulse_cnt_d = '0;
               end else begin
                  pulse_cnt_d = pulse_cnt_q + 1'b1;
               end
            end
            S_SWEEP: begin
               if (sweep_idx_q == IN_W'(OUT_W - 1)) begin
                  state_d     = S_IDLE;
                  out_d       = '0;
                  done_d      = 1'b1;
                  sweep_idx_d = '0;
               end else begin
                  // Rotating left walks the hot bit upward and wraps from the MSB to bit 0.
                  sweep_idx_d = sweep_idx_q + 1'b1;
                  out_d       = {out[OUT_W-2:0], out[OUT_W-1]};
               end
            end
            default: begin
               state_d = S_IDLE;
               out_d   = '0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         out         <= '0;
         done        <= 1'b0;
         pulse_cnt_q <= '0;
         sweep_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         out         <= out_d;
         done        <= done_d;
         pulse_cnt_q <= pulse_cnt_d;
         sweep_idx_q <= sweep_idx_d;
      end
   end

endmodule
